// File: rtl/attn_working_memory_pkg.sv
// Shared types for the attention working memory: widths, winner codes,
// store entry layout and the FSM state encoding.
// Optional macro WM_DECAY_EN adds a per-entry lifetime counter.
package pst_pkg;

  localparam int unsigned WIN_W = 3;
  localparam int unsigned REL_W = 8;
`ifdef WM_DECAY_EN
  localparam int unsigned LIFE_W = 8;
`endif

  // Winner pair codes; 6..7 are illegal
  typedef enum logic [WIN_W-1:0] {
    W_AB = 3'd0,
    W_AC = 3'd1,
    W_AD = 3'd2,
    W_BC = 3'd3,
    W_BD = 3'd4,
    W_CD = 3'd5
  } winner_e;

  typedef struct packed {
    logic             valid;
    logic [WIN_W-1:0] code;
    logic [REL_W-1:0] rel;
`ifdef WM_DECAY_EN
    logic [LIFE_W-1:0] life;
`endif
  } wm_entry_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_UPDATE = 2'd2
  } wm_state_e;

endpackage

// File: rtl/attn_working_memory_wm_lru_store.sv
// LRU-ordered entry store: index 0 is the most recent winner.
// Read port at rd_idx; one update per clock (move-to-front on hit,
// shift-in on miss). With WM_DECAY_EN entries age out after LIFETIME events.
module wm_lru_store
  import pst_pkg::*;
#(
  parameter int unsigned DEPTH = 4
`ifdef WM_DECAY_EN
  , parameter logic [REL_W-1:0] LIFETIME = 8'd32
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(DEPTH)-1:0]     rd_idx,
  output logic                         rd_valid_c,
  output logic [WIN_W-1:0]             rd_code_c,
  input  logic                         upd_en,
  input  logic                         upd_hit,
  input  logic [$clog2(DEPTH)-1:0]     upd_k,
  input  logic [WIN_W-1:0]             upd_code,
  input  logic [REL_W-1:0]             upd_rel,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wm_entry_t            entries_q [DEPTH];
  wm_entry_t            entries_d [DEPTH];
  wm_entry_t            new_e;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;

  assign rd_valid_c = entries_q[rd_idx].valid;
  assign rd_code_c  = entries_q[rd_idx].code;
  assign count      = count_q;

  // Next store contents: shift older entries down, write winner at the front
  always_comb begin
    entries_d = entries_q;
    new_e       = '0;
    new_e.valid = 1'b1;
    new_e.code  = upd_code;
    new_e.rel   = upd_rel;
    if (upd_en) begin
      for (int j = 1; j < int'(DEPTH); j++) begin
        if (!upd_hit || IDX_W'(j) <= upd_k) begin
          entries_d[j] = entries_q[j-1];
        end
      end
      entries_d[0] = new_e;
`ifdef WM_DECAY_EN
      for (int j = 1; j < int'(DEPTH); j++) begin
        if (entries_d[j].valid) begin
          if (entries_d[j].life != '1) begin
            entries_d[j].life = entries_d[j].life + LIFE_W'(1);
          end
          if (entries_d[j].life >= LIFETIME) begin
            entries_d[j].valid = 1'b0;
          end
        end
      end
`endif
    end
    count_d = '0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      count_d = count_d + CNT_W'(entries_d[j].valid);
    end
  end

  // Store and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entries_q <= '{default: '0};
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/attn_working_memory.sv
// Attention working memory: sequential LRU search of recent winners,
// hit/miss reporting, novelty eta boost on a miss and a stability flag.
// Optional macro WM_DECAY_EN enables entry expiry after LIFETIME events.
module attn_working_memory
  import pst_pkg::*;
#(
  parameter int unsigned      DEPTH       = 4,
  parameter logic [REL_W-1:0] REL_MIN     = 8'd16,
  parameter int unsigned      BOOST_SHIFT = 2,
  parameter int unsigned      STABLE_N    = 4,
  parameter logic [REL_W-1:0] LIFETIME    = 8'd32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        win_valid,
  input  logic [WIN_W-1:0]            winner,
  input  logic [REL_W-1:0]            winner_rel,
  output logic                        busy,
  output logic                        result_valid,
  output logic                        match,
  output logic [$clog2(DEPTH)-1:0]    match_age,
  output logic                        gated,
  output logic [7:0]                  novelty_boost,
  output logic                        stable,
  output logic [$clog2(DEPTH+1)-1:0]  wm_count,
  output logic [7:0]                  drop_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  wm_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [REL_W-1:0]  rel_q, rel_d;
  logic              hit_q, hit_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic              match_q, match_d;
  logic [IDX_W-1:0]  age_q, age_d;
  logic              gated_q, gated_d;
  logic [7:0]        boost_q, boost_d;
  logic              stable_q, stable_d;
  logic [2:0]        stab_cnt_q, stab_cnt_d;
  logic [WIN_W-1:0]  prev_q, prev_d;
  logic [7:0]        drop_q, drop_d;

  logic              rd_valid_c;
  logic [WIN_W-1:0]  rd_code_c;
  logic              upd_en;

  wm_lru_store #(
    .DEPTH    (DEPTH)
`ifdef WM_DECAY_EN
    , .LIFETIME (LIFETIME)
`endif
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (idx_q),
    .rd_valid_c (rd_valid_c),
    .rd_code_c  (rd_code_c),
    .upd_en     (upd_en),
    .upd_hit    (hit_q),
    .upd_k      (idx_q),
    .upd_code   (win_q),
    .upd_rel    (rel_q),
    .count      (wm_count)
  );

`ifndef WM_DECAY_EN
  logic unused_lifetime;
  assign unused_lifetime = ^LIFETIME;
`endif

  // Next-state, search step and result computation
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    win_d      = win_q;
    rel_d      = rel_q;
    hit_d      = hit_q;
    rv_d       = 1'b0;
    match_d    = match_q;
    age_d      = age_q;
    gated_d    = gated_q;
    boost_d    = boost_q;
    stable_d   = stable_q;
    stab_cnt_d = stab_cnt_q;
    prev_d     = prev_q;
    drop_d     = drop_q;
    upd_en     = 1'b0;

    if (win_valid && state_q != S_IDLE && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          win_d = winner;
          rel_d = winner_rel;
          if (winner_rel < REL_MIN || winner > W_CD) begin
            rv_d    = 1'b1;
            gated_d = 1'b1;
            match_d = 1'b0;
            boost_d = 8'd0;
          end else begin
            state_d = S_SEARCH;
            idx_d   = '0;
            hit_d   = 1'b0;
          end
        end
      end
      S_SEARCH: begin
        if (rd_valid_c && rd_code_c == win_q) begin
          hit_d   = 1'b1;
          state_d = S_UPDATE;
        end else if (idx_q == IDX_W'(DEPTH - 1)) begin
          hit_d   = 1'b0;
          state_d = S_UPDATE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_UPDATE: begin
        upd_en  = 1'b1;
        rv_d    = 1'b1;
        gated_d = 1'b0;
        match_d = hit_q;
        age_d   = hit_q ? idx_q : '0;
        boost_d = hit_q ? 8'd0 : 8'((8'd255 - rel_q) >> BOOST_SHIFT);
        if (stab_cnt_q != 3'd0 && win_q == prev_q) begin
          stab_cnt_d = (stab_cnt_q != 3'd7) ? stab_cnt_q + 3'd1 : stab_cnt_q;
        end else begin
          stab_cnt_d = 3'd1;
        end
        prev_d   = win_q;
        stable_d = (32'(stab_cnt_d) >= STABLE_N);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      win_q      <= '0;
      rel_q      <= '0;
      hit_q      <= 1'b0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      match_q    <= 1'b0;
      age_q      <= '0;
      gated_q    <= 1'b0;
      boost_q    <= '0;
      stable_q   <= 1'b0;
      stab_cnt_q <= '0;
      prev_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      win_q      <= win_d;
      rel_q      <= rel_d;
      hit_q      <= hit_d;
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      match_q    <= match_d;
      age_q      <= age_d;
      gated_q    <= gated_d;
      boost_q    <= boost_d;
      stable_q   <= stable_d;
      stab_cnt_q <= stab_cnt_d;
      prev_q     <= prev_d;
      drop_q     <= drop_d;
    end
  end

  assign busy          = busy_q;
  assign result_valid  = rv_q;
  assign match         = match_q;
  assign match_age     = age_q;
  assign gated         = gated_q;
  assign novelty_boost = boost_q;
  assign stable        = stable_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_attn_working_memory.sv
// Directed self-checking bench for attn_working_memory (DEPTH=4).
// Under WM_DECAY_EN a second instance with LIFETIME=3 checks entry expiry.
module tb_attn_working_memory;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       win_valid = 1'b0;
  logic [2:0] winner = 3'd0;
  logic [7:0] winner_rel = 8'd0;
  logic       busy, result_valid, match, gated, stable;
  logic [1:0] match_age;
  logic [7:0] novelty_boost, drop_cnt;
  logic [2:0] wm_count;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int rv_cnt;

  always #5 clk = ~clk;

  attn_working_memory #(
    .DEPTH(4), .REL_MIN(8'd16), .BOOST_SHIFT(2), .STABLE_N(4), .LIFETIME(8'd32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .winner(winner),
    .winner_rel(winner_rel), .busy(busy), .result_valid(result_valid),
    .match(match), .match_age(match_age), .gated(gated),
    .novelty_boost(novelty_boost), .stable(stable), .wm_count(wm_count),
    .drop_cnt(drop_cnt)
  );

`ifdef WM_DECAY_EN
  logic       d_valid = 1'b0;
  logic [2:0] d_winner = 3'd0;
  logic [7:0] d_rel = 8'd0;
  logic       d_busy, d_rv, d_match, d_gated, d_stable;
  logic [1:0] d_age;
  logic [7:0] d_boost, d_drop;
  logic [2:0] d_count;

  attn_working_memory #(
    .DEPTH(4), .REL_MIN(8'd16), .BOOST_SHIFT(2), .STABLE_N(4), .LIFETIME(8'd3)
  ) dut_decay (
    .clk(clk), .rst_n(rst_n), .win_valid(d_valid), .winner(d_winner),
    .winner_rel(d_rel), .busy(d_busy), .result_valid(d_rv),
    .match(d_match), .match_age(d_age), .gated(d_gated),
    .novelty_boost(d_boost), .stable(d_stable), .wm_count(d_count),
    .drop_cnt(d_drop)
  );

  task automatic d_send(input logic [2:0] w, input logic [7:0] r, output int l);
    @(negedge clk);
    d_valid = 1'b1; d_winner = w; d_rel = r;
    @(posedge clk); #1;
    d_valid = 1'b0;
    l = 1;
    while (!d_rv && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Strobe one winner and wait (bounded) for its result
  task automatic send(input logic [2:0] w, input logic [7:0] r, output int l);
    @(negedge clk);
    win_valid = 1'b1; winner = w; winner_rel = r;
    @(posedge clk); #1;
    win_valid = 1'b0;
    l = 1;
    while (!result_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic check_res(input string tag, input int l_exp, input logic m_exp,
                           input logic [1:0] a_exp, input logic g_exp,
                           input logic [7:0] b_exp, input logic s_exp,
                           input logic [2:0] c_exp);
    check({tag, ".lat"},    32'(lat), 32'(l_exp));
    check({tag, ".match"},  32'(match), 32'(m_exp));
    if (m_exp) check({tag, ".age"}, 32'(match_age), 32'(a_exp));
    check({tag, ".gated"},  32'(gated), 32'(g_exp));
    check({tag, ".boost"},  32'(novelty_boost), 32'(b_exp));
    check({tag, ".stable"}, 32'(stable), 32'(s_exp));
    check({tag, ".count"},  32'(wm_count), 32'(c_exp));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy",  32'(busy), 32'd0);
    check("rst.rv",    32'(result_valid), 32'd0);
    check("rst.match", 32'(match), 32'd0);
    check("rst.boost", 32'(novelty_boost), 32'd0);
    check("rst.count", 32'(wm_count), 32'd0);
    check("rst.drop",  32'(drop_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Fill the store: 0,1,2,3 all misses
    send(3'd0, 8'd200, lat); check_res("m0", 6, 0, 0, 0, 8'd13, 0, 3'd1);
    @(posedge clk); #1;
    check("m0.pulse", 32'(result_valid), 32'd0);
    send(3'd1, 8'd200, lat); check_res("m1", 6, 0, 0, 0, 8'd13, 0, 3'd2);
    send(3'd2, 8'd200, lat); check_res("m2", 6, 0, 0, 0, 8'd13, 0, 3'd3);
    send(3'd3, 8'd200, lat); check_res("m3", 6, 0, 0, 0, 8'd13, 0, 3'd4);
    // Order 3,2,1,0 -> hit at 2, order becomes 1,3,2,0
    send(3'd1, 8'd200, lat); check_res("h1", 5, 1, 2, 0, 8'd0, 0, 3'd4);
    // Miss evicts 0 -> 4,1,3,2
    send(3'd4, 8'd200, lat); check_res("m4", 6, 0, 0, 0, 8'd13, 0, 3'd4);
    // Hit 2 at age 3 -> 2,4,1,3
    send(3'd2, 8'd200, lat); check_res("h2", 6, 1, 3, 0, 8'd0, 0, 3'd4);
    // 0 was evicted -> miss, order 0,2,4,1
    send(3'd0, 8'd200, lat); check_res("m0b", 6, 0, 0, 0, 8'd13, 0, 3'd4);

    // Gated events: low relevance and illegal code
    send(3'd5, 8'd10, lat);  check_res("g5", 1, 0, 0, 1, 8'd0, 0, 3'd4);
    send(3'd7, 8'd200, lat); check_res("g7", 1, 0, 0, 1, 8'd0, 0, 3'd4);
    // Store unchanged by gating: 1 still at age 3 -> 1,0,2,4
    send(3'd1, 8'd200, lat); check_res("h1b", 6, 1, 3, 0, 8'd0, 0, 3'd4);

    // Stability: four consecutive 2s
    send(3'd2, 8'd200, lat); check_res("s1", 5, 1, 2, 0, 8'd0, 0, 3'd4);
    send(3'd2, 8'd200, lat); check_res("s2", 3, 1, 0, 0, 8'd0, 0, 3'd4);
    send(3'd2, 8'd200, lat); check_res("s3", 3, 1, 0, 0, 8'd0, 0, 3'd4);
    send(3'd2, 8'd200, lat); check_res("s4", 3, 1, 0, 0, 8'd0, 1, 3'd4);
    // Gated event does not break the run
    send(3'd2, 8'd10, lat);  check_res("sg", 1, 0, 0, 1, 8'd0, 1, 3'd4);
    send(3'd2, 8'd200, lat); check_res("s5", 3, 1, 0, 0, 8'd0, 1, 3'd4);
    // Order 2,1,0,4: 3 misses, run broken -> 3,2,1,0
    send(3'd3, 8'd200, lat); check_res("s6", 6, 0, 0, 0, 8'd13, 0, 3'd4);

    // Strobe dropped while searching for 0 (age 3)
    @(negedge clk);
    win_valid = 1'b1; winner = 3'd0; winner_rel = 8'd100;
    @(posedge clk); #1;
    win_valid = 1'b0;
    @(negedge clk);
    win_valid = 1'b1; winner = 3'd5; winner_rel = 8'd200;
    @(posedge clk); #1;
    win_valid = 1'b0;
    rv_cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (result_valid) rv_cnt++;
    end
    check("drop.rv_cnt", 32'(rv_cnt), 32'd1);
    check("drop.cnt",    32'(drop_cnt), 32'd1);
    check("drop.match",  32'(match), 32'd1);
    check("drop.age",    32'(match_age), 32'd3);

    // Reset mid-SEARCH discards the event
    @(negedge clk);
    win_valid = 1'b1; winner = 3'd5; winner_rel = 8'd200;
    @(posedge clk); #1;
    win_valid = 1'b0;
    check("srch.busy", 32'(busy), 32'd1);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("mrst.busy",  32'(busy), 32'd0);
    check("mrst.count", 32'(wm_count), 32'd0);
    check("mrst.rv",    32'(result_valid), 32'd0);
    check("mrst.drop",  32'(drop_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    rv_cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (result_valid) rv_cnt++;
    end
    check("mrst.no_rv", 32'(rv_cnt), 32'd0);

    // Relevance boundaries and boost values on an empty store
    send(3'd0, 8'd200, lat); check_res("b0", 6, 0, 0, 0, 8'd13, 0, 3'd1);
    send(3'd1, 8'd16, lat);  check_res("b16", 6, 0, 0, 0, 8'd59, 0, 3'd2);
    send(3'd1, 8'd15, lat);  check_res("b15", 1, 0, 0, 1, 8'd0, 0, 3'd2);
    send(3'd2, 8'd16, lat);  check_res("bmin", 6, 0, 0, 0, 8'd59, 0, 3'd3);
    send(3'd3, 8'd255, lat); check_res("bmax", 6, 0, 0, 0, 8'd0, 0, 3'd4);

`ifdef WM_DECAY_EN
    // LIFETIME=3: entry 0 expires after three other inserts
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b1;
    d_send(3'd0, 8'd200, lat); check("dec.m0", 32'(d_match), 32'd0);
    d_send(3'd1, 8'd200, lat);
    d_send(3'd2, 8'd200, lat);
    d_send(3'd3, 8'd200, lat);
    check("dec.count", 32'(d_count), 32'd3);
    d_send(3'd0, 8'd200, lat);
    check("dec.lat",   32'(lat), 32'd6);
    check("dec.miss",  32'(d_match), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/attn_working_memory.md
Name: attn_working_memory

Overview:
- Sits directly downstream of the closed-loop attention stage and consumes its per-gamma-cycle winner pair code (0=AB..5=CD) and winner relevance.
- Holds the most recent distinct winners in an LRU-ordered store and searches it sequentially on each new winner.
- Reports hit/miss and hit age, and issues a novelty learning-rate boost on a miss (surprise → faster STDP) plus a stability flag.
- Its boost output feeds the STDP/predictor `eta_boost` inputs of the next brain revision.

Parameters:
- DEPTH, 4, number of memory entries (2..8).
- REL_MIN, 8'd16, relevance below this gates the event (no attention, no store update).
- BOOST_SHIFT, 2, miss boost = (255 − rel) >> BOOST_SHIFT.
- STABLE_N, 4, consecutive identical accepted winners required to assert `stable`.
- LIFETIME, 8'd32, entry expiry in accepted events (used only with WM_DECAY_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, synchronous active-low.
- win_valid  in  1  one-clock strobe; integrator drives it one clock after cycle_start so the registered winner is settled.
- winner  in  3  winner pair code 0..5; 6..7 are illegal and treated as gated.
- winner_rel  in  8  winner relevance.
- busy  out  1  FSM not in IDLE.
- result_valid  out  1  one-clock pulse when the outputs below update.
- match  out  1  winner found in the store.
- match_age  out  $clog2(DEPTH)  index of the hit (0 = most recent).
- gated  out  1  last event was below REL_MIN or illegal.
- novelty_boost  out  8  eta boost for the last event.
- stable  out  1  same winner for ≥STABLE_N consecutive accepted events.
- wm_count  out  $clog2(DEPTH+1)  number of valid entries.
- drop_cnt  out  8  saturating count of win_valid strobes dropped while busy.

Behaviour:
- Reset (rst_n=0 at a clk edge): all entries invalid; every output is 0; FSM goes to IDLE. Applies in any state, including mid-SEARCH; the in-flight event is discarded without a result_valid.
- FSM states: IDLE, SEARCH, UPDATE.
- IDLE, on win_valid:
  - Latch winner and rel.
  - If rel < REL_MIN or winner > 5: next clock pulse result_valid with gated=1, match=0, boost=0. Store, stable and the stability counter are unchanged. Stay in IDLE.
  - Otherwise go to SEARCH with index i=0.
- SEARCH: compare entry i (valid && code==winner), one entry per clock.
  - On the first hit, or after i=DEPTH−1, go to UPDATE.
  - A hit records match=1 and match_age=i; the lowest index wins.
- UPDATE (one clock):
  - On a hit at k: entries 0..k−1 shift to 1..k; the hit entry moves to 0 with rel refreshed.
  - On a miss: all entries shift up by one, the oldest (DEPTH−1) is evicted, and the new entry is written at 0. wm_count increments, saturating at DEPTH.
  - novelty_boost = miss ? (8'd255 − rel) >> BOOST_SHIFT : 0.
  - Stability counter (3-bit, saturating): if winner equals the previous accepted winner it increments, else it loads 1. stable = counter ≥ STABLE_N.
  - result_valid pulses on the clock following UPDATE. Return to IDLE.
- Latency: win_valid → result_valid = (hit index + 3) clocks on a hit, DEPTH+2 clocks on a miss, 1 clock when gated.
- win_valid while busy: the event is dropped, drop_cnt increments (saturating at 255), and the FSM is unaffected.
- Result outputs hold their values between result_valid pulses.

Optional Feature:
- Macro: WM_DECAY_EN.
- When defined:
  - Each entry carries an 8-bit saturating lifetime counter.
  - In UPDATE, every surviving entry's counter increments; the written or hit entry's counter is reset to 0.
  - Entries whose counter is ≥ LIFETIME become invalid in the same UPDATE, and wm_count is recomputed.
- When undefined: no counters; entries leave the store only by LRU eviction.

Decomposition:
- Package pst_pkg holds:
  - WIN_W=3 and REL_W=8.
  - Winner code constants W_AB..W_CD.
  - typedef wm_entry_t {valid, code, rel, [lifetime under WM_DECAY_EN]}.
  - The FSM state enum.
- One sub-module, wm_lru_store, owns the entry array, the move-to-front/shift-in logic and decay. It exposes a read port at index i and an update command (hit_k / insert).

Test Plan:
- Reset, then win_valid winner=0 rel=200 → result_valid 6 clocks later; match=0, novelty_boost=13, wm_count=1, gated=0.
- Accept 0,1,2,3 (rel=200), then winner=1 → match=1, match_age=2, boost=0; store order becomes 1,3,2,0.
- With the store full as above, winner=4 → miss, 0 evicted, order 4,1,3,2, wm_count=4, boost=13.
- winner=5 rel=10 → result_valid next clock, gated=1, boost=0, store and stable unchanged; winner=7 rel=200 → gated=1.
- Four consecutive winner=2 rel=200 → stable=1 on the 4th result; then winner=3 → stable=0. A win_valid pulsed during SEARCH → drop_cnt=1 and only one result_valid.
- Assert rst_n=0 for one clock mid-SEARCH → next clock busy=0, wm_count=0, no result_valid. With WM_DECAY_EN and LIFETIME=3: insert 0, then three other distinct winners → entry 0 invalidated, and a following winner=0 is a miss.
